// File: rtl/dma_channel_scheduler.sv
// rtl/dma_channel_scheduler.sv - round-robin DMA channel scheduler feeding one shared transfer engine
module dma_channel_scheduler #(
    parameter int NCH     = 4,
    parameter int TIMEOUT = 65535,
    parameter int TW      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*32-1:0] src_addr,
    input  logic [NCH*32-1:0] dest_addr,
    input  logic [NCH*32-1:0] count_addr,
    output logic [NCH-1:0]    done,
    output logic              eng_start,
    output logic              eng_abort,
    output logic [1:0]        eng_ch,
    output logic [31:0]       eng_src,
    output logic [31:0]       eng_dest,
    output logic [31:0]       eng_count,
    input  logic              eng_done,
    output logic              busy,
    output logic [NCH-1:0]    err,
    input  logic [NCH-1:0]    err_clr
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);
    localparam bit            WD_EN   = (TIMEOUT != 0);

    logic [1:0]     state_q, state_d;
    logic [1:0]     last_grant_q, last_grant_d;
    logic [TW-1:0]  wd_q, wd_d;
    logic [1:0]     eng_ch_q, eng_ch_d;
    logic [31:0]    eng_src_q, eng_src_d;
    logic [31:0]    eng_dest_q, eng_dest_d;
    logic [31:0]    eng_count_q, eng_count_d;
    logic           eng_start_q, eng_start_d;
    logic           eng_abort_q, eng_abort_d;
    logic [NCH-1:0] done_q, done_d;
    logic           busy_q, busy_d;
    logic [NCH-1:0] err_q, err_d;

    logic           win_vld;
    logic [1:0]     win_ch;
    logic [1:0]     cand;
    logic [NCH-1:0] err_set;
    logic [31:0]    win_count;

    // Search starts one past the last grant so every requester is served within NCH grants.
    always_comb begin
        win_vld = 1'b0;
        win_ch  = 2'd0;
        cand    = 2'd0;
        for (int i = 0; i < NCH; i++) begin
            cand = last_grant_q + 2'(i + 1);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_ch  = cand;
            end
        end
    end

    assign win_count = count_addr[{win_ch, 5'd0} +: 32];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wd_d         = wd_q;
        eng_ch_d     = eng_ch_q;
        eng_src_d    = eng_src_q;
        eng_dest_d   = eng_dest_q;
        eng_count_d  = eng_count_q;
        eng_abort_d  = 1'b0;
        err_set      = '0;

        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    eng_ch_d     = win_ch;
                    eng_src_d    = src_addr[{win_ch, 5'd0} +: 32];
                    eng_dest_d   = dest_addr[{win_ch, 5'd0} +: 32];
                    eng_count_d  = win_count;
                    last_grant_d = win_ch;
                    state_d      = (win_count == 32'd0) ? DONE : START;
                end
            end
            START: begin
                wd_d    = '0;
                state_d = eng_done ? DONE : RUN;
            end
            RUN: begin
                wd_d = wd_q + TW'(1);
                if (eng_done) begin
                    state_d = DONE;
                end else if (WD_EN && (wd_q == WD_LAST)) begin
                    eng_abort_d       = 1'b1;
                    err_set[eng_ch_q] = 1'b1;
                    state_d           = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A timeout landing in the same cycle as a clear must survive.
        err_d       = (err_q & ~err_clr) | err_set;
        done_d      = (state_d == DONE) ? (NCH'(1) << eng_ch_d) : '0;
        eng_start_d = (state_d == START);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 2'd3;
            wd_q         <= '0;
            eng_ch_q     <= 2'd0;
            eng_src_q    <= 32'd0;
            eng_dest_q   <= 32'd0;
            eng_count_q  <= 32'd0;
            eng_start_q  <= 1'b0;
            eng_abort_q  <= 1'b0;
            done_q       <= '0;
            busy_q       <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wd_q         <= wd_d;
            eng_ch_q     <= eng_ch_d;
            eng_src_q    <= eng_src_d;
            eng_dest_q   <= eng_dest_d;
            eng_count_q  <= eng_count_d;
            eng_start_q  <= eng_start_d;
            eng_abort_q  <= eng_abort_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign done      = done_q;
    assign eng_start = eng_start_q;
    assign eng_abort = eng_abort_q;
    assign eng_ch    = eng_ch_q;
    assign eng_src   = eng_src_q;
    assign eng_dest  = eng_dest_q;
    assign eng_count = eng_count_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// tb/tb_dma_channel_scheduler.sv - directed bench for dma_channel_scheduler
module tb_dma_channel_scheduler;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] src_addr;
    logic [127:0] dest_addr;
    logic [127:0] count_addr;
    logic [3:0]   done;
    logic         eng_start;
    logic         eng_abort;
    logic [1:0]   eng_ch;
    logic [31:0]  eng_src;
    logic [31:0]  eng_dest;
    logic [31:0]  eng_count;
    logic         eng_done;
    logic         busy;
    logic [3:0]   err;
    logic [3:0]   err_clr;

    int n_checks = 0;
    int n_fails  = 0;

    dma_channel_scheduler #(
        .NCH     (4),
        .TIMEOUT (20),
        .TW      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .src_addr   (src_addr),
        .dest_addr  (dest_addr),
        .count_addr (count_addr),
        .done       (done),
        .eng_start  (eng_start),
        .eng_abort  (eng_abort),
        .eng_ch     (eng_ch),
        .eng_src    (eng_src),
        .eng_dest   (eng_dest),
        .eng_count  (eng_count),
        .eng_done   (eng_done),
        .busy       (busy),
        .err        (err),
        .err_clr    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] src_of(input int n);
        return 32'h1000_0000 + 32'(n * 256);
    endfunction

    function automatic logic [31:0] dest_of(input int n);
        return 32'h2000_0000 + 32'(n * 256);
    endfunction

    initial begin
        rst      = 1'b1;
        req      = 4'b0000;
        eng_done = 1'b0;
        err_clr  = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            src_addr[32*n +: 32]  = src_of(n);
            dest_addr[32*n +: 32] = dest_of(n);
        end
        count_addr[31:0]   = 32'd8;
        count_addr[63:32]  = 32'd4;
        count_addr[95:64]  = 32'd7;
        count_addr[127:96] = 32'd5;
        tick();
        tick();

        chk("rst_done", done, 0);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_eng_abort", eng_abort, 0);
        chk("rst_eng_ch", eng_ch, 0);
        chk("rst_eng_src", eng_src, 0);
        chk("rst_eng_dest", eng_dest, 0);
        chk("rst_eng_count", eng_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);

        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // single channel transfer, engine completes 10 cycles after start
        req = 4'b0001;
        tick();
        chk("t1_start", eng_start, 1);
        chk("t1_ch", eng_ch, 0);
        chk("t1_src", eng_src, 32'h1000_0000);
        chk("t1_dest", eng_dest, 32'h2000_0000);
        chk("t1_count", eng_count, 8);
        chk("t1_busy", busy, 1);
        src_addr[31:0] = 32'hDEAD_BEEF;
        tick();
        chk("t1_start_once", eng_start, 0);
        repeat (8) tick();
        tick();
        chk("t1_no_early_done", done, 0);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("t1_done", done, 4'b0001);
        chk("t1_busy_in_done", busy, 1);
        chk("t1_src_hold", eng_src, 32'h1000_0000);
        chk("t1_no_abort", eng_abort, 0);
        req = 4'b0000;
        src_addr[31:0] = 32'h1000_0000;
        tick();
        chk("t1_done_single", done, 0);
        chk("t1_busy_drop", busy, 0);

        // round robin from reset: 0,1,2,3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rr_ch%0d", k), eng_ch, k);
            chk($sformatf("rr_start%0d", k), eng_start, 1);
            chk($sformatf("rr_src%0d", k), eng_src, src_of(k));
            eng_done = 1'b1;
            tick();
            eng_done = 1'b0;
            chk($sformatf("rr_done%0d", k), done, 32'(1) << k);
            req[k] = 1'b0;
            tick();
            chk($sformatf("rr_idle%0d", k), busy, 0);
        end

        req = 4'b1001;
        tick();
        chk("rr_wrap_first", eng_ch, 0);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("rr_wrap_done0", done, 4'b0001);
        req[0] = 1'b0;
        tick();
        tick();
        chk("rr_wrap_second", eng_ch, 3);
        chk("rr_wrap_start3", eng_start, 1);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("rr_wrap_done3", done, 4'b1000);
        req = 4'b0000;
        tick();

        // zero count completes without an engine start
        count_addr[95:64] = 32'd0;
        req = 4'b0100;
        tick();
        chk("zc_done", done, 4'b0100);
        chk("zc_no_start", eng_start, 0);
        chk("zc_ch", eng_ch, 2);
        chk("zc_err", err, 0);
        req = 4'b0000;
        tick();
        chk("zc_done_single", done, 0);
        chk("zc_idle", busy, 0);
        chk("zc_no_start_after", eng_start, 0);

        // watchdog timeout on ch0
        req = 4'b0001;
        tick();
        chk("to_start", eng_start, 1);
        tick();
        repeat (19) tick();
        chk("to_pre_abort", eng_abort, 0);
        chk("to_pre_done", done, 0);
        chk("to_pre_err", err, 0);
        tick();
        chk("to_abort", eng_abort, 1);
        chk("to_err", err, 4'b0001);
        chk("to_done", done, 4'b0001);
        req = 4'b0000;
        tick();
        chk("to_abort_single", eng_abort, 0);
        chk("to_err_sticky", err, 4'b0001);
        err_clr = 4'b0001;
        tick();
        err_clr = 4'b0000;
        chk("to_err_clr", err, 0);

        // eng_done on the watchdog terminal cycle wins
        req = 4'b0010;
        tick();
        chk("col_ch", eng_ch, 1);
        tick();
        repeat (19) tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("col_done", done, 4'b0010);
        chk("col_no_abort", eng_abort, 0);
        chk("col_no_err", err, 0);
        req = 4'b0000;
        tick();

        // timeout set beats a same-cycle clear
        req = 4'b0001;
        tick();
        tick();
        repeat (19) tick();
        err_clr = 4'b0001;
        tick();
        err_clr = 4'b0000;
        chk("setwin_err", err, 4'b0001);
        chk("setwin_abort", eng_abort, 1);
        req = 4'b0000;
        tick();
        err_clr = 4'b0001;
        tick();
        err_clr = 4'b0000;
        chk("setwin_clr", err, 0);

        // stray eng_done in IDLE
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("stray_busy", busy, 0);
        chk("stray_done", done, 0);

        // reset during RUN, then restart of ch1
        req = 4'b0010;
        tick();
        tick();
        tick();
        tick();
        chk("mr_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        chk("mr_done", done, 0);
        chk("mr_abort", eng_abort, 0);
        chk("mr_busy", busy, 0);
        chk("mr_ch", eng_ch, 0);
        chk("mr_src", eng_src, 0);
        chk("mr_count", eng_count, 0);
        chk("mr_start", eng_start, 0);
        rst = 1'b0;
        tick();
        chk("mr_restart", eng_start, 1);
        chk("mr_restart_ch", eng_ch, 1);
        chk("mr_restart_src", eng_src, src_of(1));
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("mr_restart_done", done, 4'b0010);
        req = 4'b0000;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/dma_channel_scheduler.md
Name: dma_channel_scheduler

Overview:
- Sits between the APB DMA register file and the single shared AHB transfer engine.
- Arbitrates the four channel requests (config bit 0 of each channel) with round-robin, loads the winner's src/dest/count into the engine, and issues a start pulse.
- Waits for the engine to finish or for a watchdog timeout, then returns a one-cycle done pulse to the register file, which clears that channel's enable bit.

Parameters:
- NCH, 4, number of channels; fixed at 4, with bus widths fixed at NCH*32.
- TIMEOUT, 65535, RUN-state cycle limit before abort; 0 disables the watchdog.
- TW, 16, width of the watchdog counter; TIMEOUT must be less than 2^TW.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- req  in  4  per-channel enable from the register file
- src_addr  in  128  channel n occupies bits [32n+31:32n]
- dest_addr  in  128  same packing as src_addr
- count_addr  in  128  transfer count per channel, same packing
- done  out  4  one-cycle completion pulse, one-hot
- eng_start  out  1  one-cycle start strobe to the engine
- eng_abort  out  1  one-cycle abort strobe to the engine
- eng_ch  out  2  channel currently loaded into the engine
- eng_src  out  32  latched source address
- eng_dest  out  32  latched destination address
- eng_count  out  32  latched transfer count
- eng_done  in  1  engine completion pulse
- busy  out  1  high whenever the state is not IDLE
- err  out  4  sticky per-channel timeout flag
- err_clr  in  4  write-one-to-clear for err

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state = IDLE; last_grant = 3, so ch0 wins first.
  - All outputs are 0: done, eng_start, eng_abort, eng_ch, eng_src, eng_dest, eng_count, busy, err.
  - Watchdog counter = 0.
- Reset mid-transfer: returns to IDLE with no done pulse and no abort strobe.
- Arbitration:
  - Round-robin over req; search begins at last_grant+1 mod 4.
  - The winner is evaluated combinationally in IDLE only.
  - last_grant updates to the winner on the IDLE exit edge.
- IDLE:
  - If req = 0, remain in IDLE.
  - Otherwise latch eng_ch, eng_src, eng_dest and eng_count from the winner's slice.
  - If the winner's count is 0, go to DONE and issue no start.
  - Otherwise go to START.
- START:
  - eng_start = 1 for exactly this cycle; watchdog cleared to 0.
  - If eng_done = 1 in this cycle, go to DONE; otherwise go to RUN.
- RUN:
  - The watchdog counter increments each cycle.
  - If eng_done = 1, go to DONE.
  - Else, if TIMEOUT is nonzero and the counter equals TIMEOUT-1: eng_abort = 1 in the next cycle, err[eng_ch] is set, and the state goes to DONE.
  - If eng_done and the watchdog terminal count occur in the same cycle, eng_done wins: no abort and no err.
- DONE:
  - done[eng_ch] = 1 for this single cycle; next state is IDLE.
  - The register file clears req on this edge, so the following IDLE cycle cannot re-grant the same channel.
- Outputs are registered and decoded from state: eng_start (START), done (DONE), busy (not IDLE). eng_abort is registered and coincides with the first DONE cycle.
- Latency:
  - req seen in IDLE at cycle T gives eng_start at T+1.
  - eng_done at cycle X gives done at X+1 and IDLE at X+2.
  - A zero-count request gives done at T+1.
- eng_src, eng_dest, eng_count and eng_ch hold their values until the next grant; they must not follow src_addr etc. while a transfer is in flight.
- req deasserting during START or RUN is ignored; the transfer completes normally.
- err_clr:
  - Clears the matching err bits.
  - A same-cycle timeout set for the same channel wins over the clear.
- eng_done received in IDLE or DONE is ignored.

Test Plan:
- Single channel, counter-only transfer: req = 4'b0001, count0 = 8, engine pulses eng_done 10 cycles after start. Required: eng_start exactly 1 cycle after req, eng_ch = 0, eng_src = src0, done = 4'b0001 one cycle after eng_done, busy drops one cycle later.
- Round-robin fairness: req = 4'b1111 held, with each done fed back to clear its bit. Required: grant order 0, 1, 2, 3. Then re-raise req = 4'b1001 with last_grant = 3: ch0 is granted before ch3.
- Zero count: req = 4'b0100, count2 = 0. Required: no eng_start, done = 4'b0100 at T+1, no err.
- Timeout (TIMEOUT = 20): engine never completes. Required: eng_abort pulse 20 cycles after the RUN entry cycle, err = 4'b0001 and done[0] in the same cycle. err_clr = 4'b0001 then clears err to 0.
- Collision and reset: eng_done on the watchdog terminal cycle gives done with err = 0. rst asserted during RUN gives every output 0 on the next cycle and no done pulse; after rst deasserts with req still 4'b0010, ch1 restarts.
